// File: rtl/text_overlay_if.sv
// Bundle of pixel-stream, host-write, glyph-ROM and output signals of the
// text overlay. The slave side is the renderer; the master side is the
// video timing / host / ROM environment around it.
interface text_overlay_if #(
  parameter int X_W = 10,
  parameter int Y_W = 10
);
  logic [X_W-1:0] pix_x;
  logic [Y_W-1:0] pix_y;
  logic           pix_de;
  logic           pix_hs;
  logic           pix_vs;
  logic           frame_start;
  logic           wr_en;
  logic [4:0]     wr_addr;
  logic [4:0]     wr_data;
  logic           commit;
  logic           commit_pend;
  logic [4:0]     rom_char;
  logic [2:0]     rom_row;
  logic [2:0]     rom_col;
  logic           rom_dot;
  logic           out_on;
  logic           out_de;
  logic           out_hs;
  logic           out_vs;

  modport master (
    output pix_x, pix_y, pix_de, pix_hs, pix_vs, frame_start,
    output wr_en, wr_addr, wr_data, commit, rom_dot,
    input  commit_pend, rom_char, rom_row, rom_col,
    input  out_on, out_de, out_hs, out_vs
  );

  modport slave (
    input  pix_x, pix_y, pix_de, pix_hs, pix_vs, frame_start,
    input  wr_en, wr_addr, wr_data, commit, rom_dot,
    output commit_pend, rom_char, rom_row, rom_col,
    output out_on, out_de, out_hs, out_vs
  );
endinterface

// File: rtl/text_overlay.sv
// Single-line text renderer feeding a combinational glyph ROM. Each raster
// pixel is mapped onto one of COLS glyph cells, the ROM is addressed one
// cycle later, and the returned dot becomes out_on one cycle after that,
// with de/hs/vs delayed to match. Text is double-buffered: the host fills
// the back buffer and a commit copies it to the front buffer at frame_start.
module text_overlay #(
  parameter int COLS       = 16,
  parameter int X_W        = 10,
  parameter int Y_W        = 10,
  parameter int ORIGIN_X   = 0,
  parameter int ORIGIN_Y   = 0,
  parameter int SCALE_LOG2 = 0
) (
  input  logic           clk,
  input  logic           rst,
  text_overlay_if.slave  bus
);

  localparam logic [X_W-1:0] ORG_X      = X_W'(ORIGIN_X);
  localparam logic [Y_W-1:0] ORG_Y      = Y_W'(ORIGIN_Y);
  localparam logic [X_W-1:0] COLS_X     = X_W'(COLS);
  localparam logic [5:0]     COLS_A     = 6'(COLS);
  localparam logic [Y_W-1:0] GLYPH_H    = Y_W'(8);
  localparam logic [4:0]     CODE_BLANK = 5'd31;

  // Both buffers are sized for the full 5-bit cell address so any index is
  // in range; only the first COLS entries are ever written by the host.
  logic [4:0] back  [32];
  logic [4:0] front [32];
  logic       pend;

  logic [X_W-1:0] rx, gx, cell_x;
  logic [Y_W-1:0] ry, gy;
  logic           inbox;
  logic [4:0]     code;
  logic           blank;

  logic [4:0] char_p1;
  logic [2:0] row_p1, col_p1;
  logic       blank_p1, de_p1, hs_p1, vs_p1;
  logic       on_p2, de_p2, hs_p2, vs_p2;

  // Map the raster position into glyph space and look up the cell's code.
  always_comb begin
    rx     = bus.pix_x - ORG_X;
    ry     = bus.pix_y - ORG_Y;
    gx     = rx >> SCALE_LOG2;
    gy     = ry >> SCALE_LOG2;
    cell_x = gx >> 3;
    inbox  = (bus.pix_x >= ORG_X) && (bus.pix_y >= ORG_Y) &&
             (gy < GLYPH_H) && (cell_x < COLS_X);
    code   = front[cell_x[4:0]];
    blank  = !inbox || (code == CODE_BLANK);
  end

  // Host writes land in the back buffer; a pending or same-cycle commit
  // copies back to front only at frame_start, so a frame never tears.
  // The copy reads back before this cycle's write takes effect.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        back[i]  <= CODE_BLANK;
        front[i] <= CODE_BLANK;
      end
      pend <= 1'b0;
    end else begin
      if (bus.frame_start && (pend || bus.commit)) begin
        for (int i = 0; i < 32; i++) front[i] <= back[i];
        pend <= 1'b0;
      end else if (bus.commit) begin
        pend <= 1'b1;
      end
      if (bus.wr_en && ({1'b0, bus.wr_addr} < COLS_A)) begin
        back[bus.wr_addr] <= bus.wr_data;
      end
    end
  end

  // Stage 1: drive the glyph ROM address; BLANK is never sent to the ROM.
  always_ff @(posedge clk) begin
    if (rst) begin
      char_p1  <= 5'd0;
      row_p1   <= 3'd0;
      col_p1   <= 3'd0;
      blank_p1 <= 1'b1;
      de_p1    <= 1'b0;
      hs_p1    <= 1'b0;
      vs_p1    <= 1'b0;
    end else begin
      char_p1  <= blank ? 5'd0 : code;
      row_p1   <= gy[2:0];
      col_p1   <= gx[2:0];
      blank_p1 <= blank;
      de_p1    <= bus.pix_de;
      hs_p1    <= bus.pix_hs;
      vs_p1    <= bus.pix_vs;
    end
  end

  // Stage 2: register the ROM dot, qualified by active video and blanking.
  always_ff @(posedge clk) begin
    if (rst) begin
      on_p2 <= 1'b0;
      de_p2 <= 1'b0;
      hs_p2 <= 1'b0;
      vs_p2 <= 1'b0;
    end else begin
      on_p2 <= de_p1 && !blank_p1 && bus.rom_dot;
      de_p2 <= de_p1;
      hs_p2 <= hs_p1;
      vs_p2 <= vs_p1;
    end
  end

  assign bus.commit_pend = pend;
  assign bus.rom_char    = char_p1;
  assign bus.rom_row     = row_p1;
  assign bus.rom_col     = col_p1;
  assign bus.out_on      = on_p2;
  assign bus.out_de      = de_p2;
  assign bus.out_hs      = hs_p2;
  assign bus.out_vs      = vs_p2;

endmodule
